// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: definitions shared by the dual-requester RAM arbiter.
//   state_t      - arbiter FSM states (ST_INIT, ST_RUN)
//   REQ_A/REQ_B  - requester IDs, also the encoding of the round-robin pointer
package ram_arb_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage

// File: rtl/ram_sp.sv
// ram_sp: single-port synchronous RAM, 2**SIZE words of DW bits.
//   clk   - clock
//   sel   - access enable, at most one access per cycle
//   we    - 1 = write dat_i to mem[adr], 0 = read mem[adr] into dat_o
//   adr   - word address
//   dat_i - write data
//   dat_o - registered read data; holds its value when no read occurs
module ram_sp #(
  parameter int SIZE = 5,
  parameter int DW   = 64
) (
  input  logic            clk,
  input  logic            sel,
  input  logic            we,
  input  logic [SIZE-1:0] adr,
  input  logic [DW-1:0]   dat_i,
  output logic [DW-1:0]   dat_o
);

  logic [DW-1:0] mem [2**SIZE];

  always_ff @(posedge clk) begin
    if (sel) begin
      if (we) mem[adr] <= dat_i;
      else    dat_o    <= mem[adr];
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: two requesters (A, B) sharing one single-port RAM with
// round-robin arbitration and single-cycle combinational grant.
//   clk, rst_n              - clock, synchronous active-low reset
//   req_x, we_x, adr_x,     - request, write enable, address and write data
//   wdat_x                    of requester x (held stable until gnt_x)
//   gnt_x                   - access accepted this cycle (combinational)
//   rvalid_x                - rdat valid for x, one cycle after a read grant
//   rdat                    - shared read data
//   init_done               - RAM initialised, arbitration enabled
// Build option: define RAM_ARB_INIT_EN to zero-fill the RAM after reset
// (INIT state, one word per cycle) before arbitration starts.
module ram_port_arbiter #(
  parameter int SIZE = 5,
  parameter int DW   = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_a,
  input  logic            req_b,
  input  logic            we_a,
  input  logic            we_b,
  input  logic [SIZE-1:0] adr_a,
  input  logic [SIZE-1:0] adr_b,
  input  logic [DW-1:0]   wdat_a,
  input  logic [DW-1:0]   wdat_b,
  output logic            gnt_a,
  output logic            gnt_b,
  output logic            rvalid_a,
  output logic            rvalid_b,
  output logic [DW-1:0]   rdat,
  output logic            init_done
);

  import ram_arb_pkg::*;

  state_t          state, state_nxt;
  logic            rr_last;
  logic            rv_a, rv_b;
  logic            sel, we;
  logic [SIZE-1:0] adr;
  logic [DW-1:0]   dat_i;
`ifdef RAM_ARB_INIT_EN
  logic [SIZE-1:0] cnt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
`ifdef RAM_ARB_INIT_EN
      state <= ST_INIT;
`else
      state <= ST_RUN;
`endif
      rr_last <= REQ_B;
      rv_a    <= 1'b0;
      rv_b    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (gnt_a)      rr_last <= REQ_A;
      else if (gnt_b) rr_last <= REQ_B;
      rv_a <= gnt_a & ~we_a;
      rv_b <= gnt_b & ~we_b;
    end
  end

`ifdef RAM_ARB_INIT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)                 cnt <= '0;
    else if (state == ST_INIT)  cnt <= cnt + SIZE'(1);
  end
`endif

  // Everything is gated by rst_n so that, with the reset being synchronous,
  // no grant, RAM access or rvalid leaks out during a reset cycle. Without
  // the init option the register already holds ST_RUN, so the first cycle
  // with rst_n=1 is a RUN cycle.
  always_comb begin
    state_nxt = state;
    gnt_a     = 1'b0;
    gnt_b     = 1'b0;
    sel       = 1'b0;
    we        = 1'b0;
    adr       = '0;
    dat_i     = '0;
    if (rst_n) begin
      case (state)
        ST_INIT: begin
`ifdef RAM_ARB_INIT_EN
          sel   = 1'b1;
          we    = 1'b1;
          adr   = cnt;
          if (cnt == '1) state_nxt = ST_RUN;
`endif
        end
        ST_RUN: begin
          // On contention the requester not granted most recently wins.
          if (req_a && (!req_b || rr_last == REQ_B)) gnt_a = 1'b1;
          else if (req_b)                            gnt_b = 1'b1;
          sel   = gnt_a | gnt_b;
          we    = gnt_a ? we_a   : we_b;
          adr   = gnt_a ? adr_a  : adr_b;
          dat_i = gnt_a ? wdat_a : wdat_b;
        end
      endcase
    end
  end

  assign rvalid_a  = rv_a & rst_n;
  assign rvalid_b  = rv_b & rst_n;
  assign init_done = rst_n && (state == ST_RUN);

  ram_sp #(
    .SIZE (SIZE),
    .DW   (DW)
  ) u_ram (
    .clk   (clk),
    .sel   (sel),
    .we    (we),
    .adr   (adr),
    .dat_i (dat_i),
    .dat_o (rdat)
  );

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: self-checking bench for ram_port_arbiter against a
// behavioural model (word array + known flags, round-robin winner, init
// countdown). Handles builds with and without RAM_ARB_INIT_EN.
module tb_ram_port_arbiter;

  localparam int SIZE  = 5;
  localparam int DW    = 64;
  localparam int DEPTH = 1 << SIZE;
`ifdef RAM_ARB_INIT_EN
  localparam int INIT_CYCLES = DEPTH;
`else
  localparam int INIT_CYCLES = 0;
`endif

  logic            clk = 1'b0;
  logic            rst_n, req_a, req_b, we_a, we_b;
  logic [SIZE-1:0] adr_a, adr_b;
  logic [DW-1:0]   wdat_a, wdat_b;
  logic            gnt_a, gnt_b, rvalid_a, rvalid_b, init_done;
  logic [DW-1:0]   rdat;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .SIZE (SIZE),
    .DW   (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_a     (req_a),
    .req_b     (req_b),
    .we_a      (we_a),
    .we_b      (we_b),
    .adr_a     (adr_a),
    .adr_b     (adr_b),
    .wdat_a    (wdat_a),
    .wdat_b    (wdat_b),
    .gnt_a     (gnt_a),
    .gnt_b     (gnt_b),
    .rvalid_a  (rvalid_a),
    .rvalid_b  (rvalid_b),
    .rdat      (rdat),
    .init_done (init_done)
  );

  // Reference model state
  logic [DW-1:0] m_mem   [DEPTH];
  bit            m_known [DEPTH];
  int            m_init_left = INIT_CYCLES;
  bit            m_last_b    = 1'b1;
  bit            m_rv_a, m_rv_b, m_rv_known;
  logic [DW-1:0] m_rv_dat;
  bit            e_ga, e_gb;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Check outputs mid-cycle, then advance the model across the next edge.
  task automatic step();
    bit            run;
    int            a;
    bit            w;
    logic [DW-1:0] d;
    @(negedge clk);
    run  = rst_n && (m_init_left == 0);
    e_ga = 1'b0;
    e_gb = 1'b0;
    if (run) begin
      if (req_a && req_b) begin
        if (m_last_b) e_ga = 1'b1;
        else          e_gb = 1'b1;
      end else begin
        e_ga = req_a;
        e_gb = req_b;
      end
    end
    check("gnt_a",     64'(gnt_a),     64'(e_ga));
    check("gnt_b",     64'(gnt_b),     64'(e_gb));
    check("rvalid_a",  64'(rvalid_a),  64'(rst_n && m_rv_a));
    check("rvalid_b",  64'(rvalid_b),  64'(rst_n && m_rv_b));
    check("init_done", 64'(init_done), 64'(run));
    if (rst_n && (m_rv_a || m_rv_b) && m_rv_known)
      check("rdat", rdat, m_rv_dat);

    if (!rst_n) begin
      m_init_left = INIT_CYCLES;
      m_last_b    = 1'b1;
      m_rv_a      = 1'b0;
      m_rv_b      = 1'b0;
    end else begin
      m_rv_a = e_ga && !we_a;
      m_rv_b = e_gb && !we_b;
      if (m_init_left > 0) begin
        a          = DEPTH - m_init_left;
        m_mem[a]   = '0;
        m_known[a] = 1'b1;
        m_init_left--;
      end else if (e_ga || e_gb) begin
        a = e_ga ? int'(adr_a) : int'(adr_b);
        w = e_ga ? we_a : we_b;
        d = e_ga ? wdat_a : wdat_b;
        if (w) begin
          m_mem[a]   = d;
          m_known[a] = 1'b1;
        end else begin
          m_rv_dat   = m_mem[a];
          m_rv_known = m_known[a];
        end
        m_last_b = e_gb;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input bit r, input bit w, input int adr, input logic [DW-1:0] d);
    req_a = r; we_a = w; adr_a = SIZE'(adr); wdat_a = d;
  endtask

  task automatic drv_b(input bit r, input bit w, input int adr, input logic [DW-1:0] d);
    req_b = r; we_b = w; adr_b = SIZE'(adr); wdat_b = d;
  endtask

  initial begin
    bit pa = 1'b0;
    bit pb = 1'b0;
    rst_n = 1'b0;
    drv_a(0, 0, 0, '0);
    drv_b(0, 0, 0, '0);
    repeat (2) @(posedge clk);
    #1;

    // Requests during reset are ignored
    drv_a(1, 1, 5, 64'h1234);
    step();
    step();

    // Release reset with an A write pending: granted at once, or after init
    rst_n = 1'b1;
    drv_a(1, 1, 9, 64'hA5A5_5A5A_0F0F_F0F0);
    step();
    repeat (INIT_CYCLES) step();

    // Reads of 0, 17, 31 (zero after init)
    drv_a(1, 0, 0, '0);  step();
    drv_a(1, 0, 17, '0); step();
    drv_a(1, 0, 31, '0); step();
    drv_a(0, 0, 0, '0);  step();

    // Write then immediate read of the same address by the other requester
    drv_a(1, 1, 3, 64'hDEAD_BEEF_0000_0001); step();
    drv_a(0, 0, 0, '0);
    drv_b(1, 0, 3, '0);                      step();
    drv_b(0, 0, 0, '0);                      step();

    // Sustained contention: alternates A,B,A,B,A,B
    drv_a(1, 0, 9, '0);
    drv_b(1, 0, 3, '0);
    repeat (6) step();
    drv_a(0, 0, 0, '0);
    drv_b(0, 0, 0, '0);
    step();

    // B alone for 4 cycles, then contention: A wins first
    drv_b(1, 0, 9, '0);
    repeat (4) step();
    drv_a(1, 0, 3, '0);
    repeat (3) step();
    drv_a(0, 0, 0, '0);
    drv_b(0, 0, 0, '0);
    step();

    // Randomised traffic, each request held until granted
    repeat (600) begin
      if (!pa && $urandom_range(0, 3) != 0) begin
        pa = 1'b1;
        drv_a(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), {$urandom, $urandom});
      end
      if (!pb && $urandom_range(0, 3) != 0) begin
        pb = 1'b1;
        drv_b(1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), {$urandom, $urandom});
      end
      req_a = pa;
      req_b = pb;
      step();
      if (e_ga) pa = 1'b0;
      if (e_gb) pb = 1'b0;
    end
    drv_a(0, 0, 0, '0);
    drv_b(0, 0, 0, '0);
    step();

    // Reset pulse while an A read is in flight
    drv_a(1, 0, 3, '0); step();
    drv_a(0, 0, 0, '0);
    rst_n = 1'b0;       step();
    rst_n = 1'b1;
    repeat (INIT_CYCLES + 2) step();

    // Pointer back to its reset value: A wins first contention
    drv_a(1, 0, 3, '0);
    drv_b(1, 0, 17, '0);
    repeat (2) step();
    drv_a(0, 0, 0, '0);
    drv_b(0, 0, 0, '0);
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter SIZE, default 5, address width; the RAM depth is 2**SIZE words.
REQ-002 Parameter DW, default 64, data width.
REQ-003 clk  in  1  single clock; all logic updates on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous and active-low.
REQ-005 req_a / req_b  in  1  access request from requester A / B.
REQ-006 we_a / we_b  in  1  1 = write, 0 = read.
REQ-007 adr_a / adr_b  in  SIZE  word address.
REQ-008 wdat_a / wdat_b  in  DW  write data.
REQ-009 gnt_a / gnt_b  out  1  access accepted this cycle (combinational).
REQ-010 rvalid_a / rvalid_b  out  1  read data valid for that requester.
REQ-011 rdat  out  DW  read data, shared, meaningful only while an rvalid is high.
REQ-012 init_done  out  1  RAM contents initialised; arbitration enabled.

Function
REQ-013 Instantiate one single-port synchronous RAM: at most one access (sel) per cycle, write when we=1, otherwise a registered read.
REQ-014 FSM states: INIT, RUN; INIT exists only per REQ-027.
REQ-015 In RUN, a requester with req high and no competitor SHALL get gnt in the same cycle, and the RAM access SHALL occur on that edge.
REQ-016 When req_a and req_b are both high, grant round-robin: the requester not granted most recently wins; the pointer updates only on a grant.
REQ-017 Round-robin pointer reset value: B last-granted, so A wins the first contention.
REQ-018 gnt_a and gnt_b SHALL never be high together; each gnt SHALL be high only with its own req high.
REQ-019 A requester SHALL hold req, we, adr and wdat stable until gnt; the arbiter SHALL not queue requests.
REQ-020 Read latency: rvalid_x SHALL be high exactly one cycle after a read gnt_x, with rdat holding mem[adr] from the grant cycle.
REQ-021 A write followed by a read of the same address in the next cycle SHALL return the new data.
REQ-022 Back-to-back grants SHALL be possible every cycle (100% throughput).
REQ-023 While not in RUN, gnt_a, gnt_b, rvalid_a and rvalid_b SHALL be 0.

Reset
REQ-024 While rst_n=0: gnt_*=0, rvalid_*=0, init_done=0, pointer=B, FSM = INIT (or RUN if the macro is absent), init counter = 0.
REQ-025 rst_n asserted mid-operation SHALL drop any pending rvalid, abort INIT, and restart from REQ-024 at the next edge.
REQ-026 rdat is not reset; its value is don't-care while both rvalid are 0.

Configuration
REQ-027 Macro RAM_ARB_INIT_EN defined: after reset the FSM sits in INIT and writes 0 to addresses 0 .. 2**SIZE-1, one per cycle with an incrementing counter. After the last write (2**SIZE cycles) it moves to RUN and sets init_done=1 in the same cycle. Requests are ignored during INIT.
REQ-028 Macro RAM_ARB_INIT_EN undefined: no INIT state and no counter. The FSM enters RUN on the first edge with rst_n=1, and init_done=1 from that cycle. RAM contents are undefined until written.

Structure
REQ-029 The shared package ram_arb_pkg SHALL hold the FSM state typedef (ST_INIT, ST_RUN) and the requester ID constants (REQ_A=0, REQ_B=1).
REQ-030 The RAM SHALL be the single sub-module ram_sp (parameters SIZE and DW; ports clk, sel, we, adr, dat_i, dat_o). All arbitration, FSM and rvalid logic SHALL sit in ram_port_arbiter.

Verification
REQ-031 With RAM_ARB_INIT_EN, SIZE=5: release reset -> init_done rises after exactly 32 cycles; reads of addresses 0, 17 and 31 return 0.
REQ-032 A writes 0xDEAD_BEEF_0000_0001 to 3; next cycle B reads 3 -> gnt_b that cycle, rvalid_b one cycle later, rdat = 0xDEAD_BEEF_0000_0001.
REQ-033 req_a and req_b held high with reads for 6 cycles -> grants A,B,A,B,A,B; never both gnt high.
REQ-034 Only req_b high for 4 cycles -> gnt_b every cycle; then contention -> A wins first.
REQ-035 rst_n pulsed low for 1 cycle while an A read is in flight -> rvalid_a stays 0; init restarts (init_done=0 for 32 cycles).
REQ-036 Without RAM_ARB_INIT_EN: first cycle after reset release, req_a write -> gnt_a=1 immediately; init_done=1.
